fetch_stage: RTL and testbench

- IF stage of the 5-stage pipeline; sits directly upstream of the IF/ID register and feeds it.
- Owns the PC and next-PC selection: sequential, branch/jump redirect from EX, trap entry from MEM.
- Runs a single-outstanding instruction-memory request/response handshake; a one-entry buffer absorbs responses that arrive during a stall.
- Produces `instr/pc/pc+4/exception_code` for IF/ID and raises instruction-misaligned and access-fault exceptions.

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC ownership, single-outstanding imem fetch, one-entry response buffer
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_clk_en, i_stall       pipeline clock enable, hazard stall (shared with IF/ID)
//   i_redirect/_pc          taken branch/jump from EX
//   i_trap/_pc              trap entry / mret from MEM (wins over i_redirect)
//   o_imem_*/i_imem_*       instruction memory request/grant and response
//   o_instr_f, o_pc_f, o_pc_p4_f, o_exception_code_f, o_valid_f   to IF/ID
//   o_exception_f_stall     high while halted after a fetch exception
module fetch_stage #(
    parameter int XLEN = 2,                        // 1: 32-bit, 2: 64-bit
    localparam int W = 1 << (XLEN + 4),
    parameter logic [W-1:0] RESET_PC = '0,
    parameter logic [3:0] NO_E = 4'hf,
    parameter logic [3:0] E_INSTR_MISALIGNED = 4'h0,
    parameter logic [3:0] E_INSTR_ACCESS_FAULT = 4'h1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic         i_stall,
    input  logic         i_redirect,
    input  logic [W-1:0] i_redirect_pc,
    input  logic         i_trap,
    input  logic [W-1:0] i_trap_pc,
    output logic         o_imem_req,
    output logic [W-1:0] o_imem_addr,
    input  logic         i_imem_gnt,
    input  logic         i_imem_rvalid,
    input  logic [31:0]  i_imem_rdata,
    input  logic         i_imem_err,
    output logic [31:0]  o_instr_f,
    output logic [W-1:0] o_pc_f,
    output logic [W-1:0] o_pc_p4_f,
    output logic [3:0]   o_exception_code_f,
    output logic         o_exception_f_stall,
    output logic         o_valid_f
);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_HALT} state_t;

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] pc;
    logic         buf_valid;
    logic [31:0]  buf_instr;
    logic         buf_err;
    logic [W-1:0] buf_pc;

    logic         kill;
    logic [W-1:0] kill_pc;
    logic         live_rsp;
    logic         misaligned;
    logic         src_valid;
    logic         consume;
    logic         is_exc;

    assign kill       = i_trap | i_redirect;
    assign kill_pc    = i_trap ? i_trap_pc : i_redirect_pc;
    assign live_rsp   = (state == S_WAIT) && i_imem_rvalid;
    assign misaligned = (state == S_IDLE) && (pc[1:0] != 2'b00);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (kill) begin
            // A killed in-flight fetch must still drain its response in DROP
            case (state)
                S_WAIT, S_DROP: state_nx = i_imem_rvalid ? S_IDLE : S_DROP;
                default:        state_nx = S_IDLE;
            endcase
        end else if (consume) begin
            state_nx = is_exc ? S_HALT : S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (o_imem_req && i_imem_gnt) state_nx = S_WAIT;
                S_WAIT:  if (i_imem_rvalid) state_nx = S_IDLE;  // buffered
                S_DROP:  if (i_imem_rvalid) state_nx = S_IDLE;  // discarded
                default: state_nx = state;
            endcase
        end
    end

    // Output logic
    always_comb begin
        src_valid          = 1'b0;
        o_instr_f          = NOP;
        o_exception_code_f = NO_E;
        o_pc_f             = pc;
        if (buf_valid) begin
            src_valid          = 1'b1;
            o_instr_f          = buf_err ? NOP : buf_instr;
            o_exception_code_f = buf_err ? E_INSTR_ACCESS_FAULT : NO_E;
            o_pc_f             = buf_pc;
        end else if (live_rsp) begin
            src_valid          = 1'b1;
            o_instr_f          = i_imem_err ? NOP : i_imem_rdata;
            o_exception_code_f = i_imem_err ? E_INSTR_ACCESS_FAULT : NO_E;
        end else if (misaligned) begin
            src_valid          = 1'b1;
            o_exception_code_f = E_INSTR_MISALIGNED;
        end
    end

    assign o_valid_f           = src_valid && !kill && !i_rst;
    assign o_pc_p4_f           = o_pc_f + W'(4);
    assign o_exception_f_stall = (state == S_HALT);
    assign is_exc              = (o_exception_code_f != NO_E);
    assign consume             = o_valid_f && i_clk_en && !i_stall;
    assign o_imem_req          = (state == S_IDLE) && !buf_valid && i_clk_en
                                 && (pc[1:0] == 2'b00) && !kill && !i_rst;
    assign o_imem_addr         = pc;

    // PC and response buffer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc        <= RESET_PC;
            buf_valid <= 1'b0;
        end else if (kill) begin
            pc        <= kill_pc;
            buf_valid <= 1'b0;
        end else if (consume) begin
            // An exception entry holds the PC so HALT reports the faulting address
            if (!is_exc) pc <= pc + W'(4);
            buf_valid <= 1'b0;
        end else if (live_rsp) begin
            buf_valid <= 1'b1;
            buf_instr <= i_imem_rdata;
            buf_err   <= i_imem_err;
            buf_pc    <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
    localparam int W = 64;
    localparam logic [3:0]  NO_E  = 4'hf;
    localparam logic [3:0]  E_MIS = 4'h0;
    localparam logic [3:0]  E_AF  = 4'h1;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic         clk = 1'b0;
    logic         rst = 1'b1, clk_en = 1'b0, stall = 1'b0;
    logic         redirect = 1'b0, trap = 1'b0;
    logic [W-1:0] redirect_pc = '0, trap_pc = '0;
    logic         imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0, imem_err = 1'b0;
    logic [W-1:0] imem_addr;
    logic [31:0]  imem_rdata = '0;
    logic [31:0]  instr_f;
    logic [W-1:0] pc_f, pc_p4_f;
    logic [3:0]   exc_code;
    logic         exc_stall, valid_f;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(2), .RESET_PC('0), .NO_E(NO_E),
                  .E_INSTR_MISALIGNED(E_MIS), .E_INSTR_ACCESS_FAULT(E_AF)) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_stall(stall),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .i_trap(trap), .i_trap_pc(trap_pc),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(imem_gnt),
        .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata), .i_imem_err(imem_err),
        .o_instr_f(instr_f), .o_pc_f(pc_f), .o_pc_p4_f(pc_p4_f),
        .o_exception_code_f(exc_code), .o_exception_f_stall(exc_stall), .o_valid_f(valid_f)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [W-1:0] a);
        return a[31:0] ^ 32'h00500097;
    endfunction

    // Memory: one response owed per grant, delivered lat cycles later
    bit           mem_pend = 0;
    int           mem_cd = 0;
    logic [W-1:0] mem_addr = '0;
    bit           mem_err = 0;
    logic [W-1:0] err_addr = '1;
    int           err_pct = 0;

    task automatic cycle(input bit r, input bit st, input bit en, input bit rd, input logic [W-1:0] rpc,
                         input bit tr, input logic [W-1:0] tpc, input bit g, input int lat);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_err    = 1'($urandom_range(1));
        imem_rdata  = $urandom;
        if (mem_pend) begin
            mem_cd--;
            if (mem_cd == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                imem_err    = mem_err;
                mem_pend    = 0;
            end
        end
        rst = r; stall = st; clk_en = en;
        redirect = rd; redirect_pc = rpc; trap = tr; trap_pc = tpc;
        imem_gnt = g && !mem_pend;
        #2;
        if (imem_req && imem_gnt) begin
            mem_pend = 1;
            mem_cd   = lat;
            mem_addr = imem_addr;
            mem_err  = (imem_addr == err_addr) || ($urandom_range(99) < err_pct);
        end
    endtask

    // Behavioural model: a PC, whether a response is owed (and if it is dead),
    // a halted flag and a queue of at most one parked response
    bit           model_on = 0;
    logic [W-1:0] m_pc = '0;
    bit           m_pend = 0, m_dead = 0, m_halt = 0;
    logic [32:0]  m_q[$];          // {err, instr}
    bit           e_req, e_have, e_valid, redir;
    logic [31:0]  e_instr;
    logic [3:0]   e_code;

    always begin
        @(negedge clk);
        if (model_on) begin
            #1;
            redir  = trap || redirect;
            e_req  = !rst && !m_pend && !m_halt && m_q.size() == 0 && clk_en
                     && m_pc[1:0] == 2'b00 && !redir;
            e_have = 0; e_instr = NOP; e_code = NO_E;
            if (m_q.size() != 0) begin
                e_have  = 1;
                e_instr = m_q[0][32] ? NOP : m_q[0][31:0];
                e_code  = m_q[0][32] ? E_AF : NO_E;
            end else if (m_pend && !m_dead && imem_rvalid) begin
                e_have  = 1;
                e_instr = imem_err ? NOP : imem_rdata;
                e_code  = imem_err ? E_AF : NO_E;
            end else if (!m_pend && !m_halt && m_pc[1:0] != 2'b00) begin
                e_have = 1;
                e_code = E_MIS;
            end
            e_valid = e_have && !redir && !rst;

            chk("valid", 64'(valid_f), 64'(e_valid));
            chk("req", 64'(imem_req), 64'(e_req));
            if (e_req) chk("addr", imem_addr, m_pc);
            chk("halt_stall", 64'(exc_stall), 64'(m_halt));
            chk("pc", pc_f, m_pc);
            chk("pc_p4", pc_p4_f, m_pc + 64'd4);
            if (!redir && !rst) begin
                chk("instr", 64'(instr_f), 64'(e_instr));
                chk("code", 64'(exc_code), 64'(e_code));
            end

            if (rst) begin
                m_pc = '0; m_pend = 0; m_dead = 0; m_halt = 0; m_q.delete();
            end else if (redir) begin
                m_pc   = trap ? trap_pc : redirect_pc;
                m_q.delete();
                m_halt = 0;
                m_dead = m_pend && !imem_rvalid;
                if (imem_rvalid) m_pend = 0;
            end else begin
                if (e_valid && clk_en && !stall) begin
                    if (e_code != NO_E) m_halt = 1;
                    else m_pc = m_pc + 64'd4;
                    m_q.delete();
                end else if (m_pend && !m_dead && imem_rvalid) begin
                    m_q.push_back({imem_err, imem_rdata});
                end
                if (m_pend && imem_rvalid) begin m_pend = 0; m_dead = 0; end
                if (e_req && imem_gnt) begin m_pend = 1; m_dead = 0; end
            end
        end
    end

    function automatic logic [W-1:0] rand_target();
        logic [W-1:0] a;
        a = {32'h0, $urandom} & ~64'h3;
        case ($urandom_range(7))
            0:       a = a + 64'($urandom_range(1, 3));
            1:       a = 64'hFFFF_FFFF_FFFF_FFF8;
            default: ;
        endcase
        return a;
    endfunction

    initial begin
        cycle(1, 0, 1, 0, 0, 0, 0, 0, 1);
        model_on = 1;
        cycle(1, 0, 1, 0, 0, 0, 0, 0, 1);
        // sequential fetch, 1-cycle memory
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("rst_req", 64'(imem_req), 64'd1); chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", 64'(valid_f), 64'd0); chk("rst_instr", 64'(instr_f), 64'h13);
        chk("rst_code", 64'(exc_code), 64'hf); chk("rst_stall", 64'(exc_stall), 64'd0);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("seq0_valid", 64'(valid_f), 64'd1); chk("seq0_instr", 64'(instr_f), 64'h00500097);
        chk("seq0_pc", pc_f, 64'h0); chk("seq0_p4", pc_p4_f, 64'h4);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("seq1_addr", imem_addr, 64'h4);
        // stall while the response at 0x4 returns
        cycle(0, 1, 1, 0, 0, 0, 0, 1, 1);
        chk("stl_instr", 64'(instr_f), 64'h00500093); chk("stl_pc", pc_f, 64'h4);
        cycle(0, 1, 1, 0, 0, 0, 0, 1, 1);
        chk("stl_req", 64'(imem_req), 64'd0); chk("stl_buf_valid", 64'(valid_f), 64'd1);
        cycle(0, 1, 1, 0, 0, 0, 0, 1, 1);
        chk("stl_buf_instr", 64'(instr_f), 64'h00500093); chk("stl_buf_pc", pc_f, 64'h4);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("stl_rel_valid", 64'(valid_f), 64'd1);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 3);
        chk("stl_next_addr", imem_addr, 64'h8);
        // redirect to 0x100 while waiting
        cycle(0, 0, 1, 1, 64'h100, 0, 0, 1, 1);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("drop_req", 64'(imem_req), 64'd0);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("drop_rvalid", 64'(imem_rvalid), 64'd1); chk("drop_valid", 64'(valid_f), 64'd0);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("redir_addr", imem_addr, 64'h100);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);
        // misaligned target, halt, trap out
        cycle(0, 0, 1, 1, 64'h102, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("mis_req", 64'(imem_req), 64'd0); chk("mis_code", 64'(exc_code), 64'h0);
        chk("mis_pc", pc_f, 64'h102); chk("mis_valid", 64'(valid_f), 64'd1);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("mis_halt", 64'(exc_stall), 64'd1); chk("mis_halt_req", 64'(imem_req), 64'd0);
        err_addr = 64'h8;
        cycle(0, 0, 1, 0, 0, 1, 64'h200, 1, 1);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("trap_addr", imem_addr, 64'h200);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);
        // access fault at 0x8
        cycle(0, 0, 1, 1, 64'h8, 0, 0, 1, 1);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("af_addr", imem_addr, 64'h8);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("af_code", 64'(exc_code), 64'h1); chk("af_instr", 64'(instr_f), 64'h13);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("af_halt", 64'(exc_stall), 64'd1);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("af_halt_req", 64'(imem_req), 64'd0);
        // trap beats redirect
        cycle(0, 0, 1, 1, 64'h400, 1, 64'h300, 1, 1);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("prio_addr", imem_addr, 64'h300);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        // reset with a response in flight; the stale response is ignored
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 3);
        cycle(1, 0, 1, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("rst2_addr", imem_addr, 64'h0);
        cycle(0, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("stale_valid", 64'(valid_f), 64'd0);

        err_addr = '1;
        err_pct  = 6;
        for (int i = 0; i < 5000; i++) begin
            cycle($urandom_range(499) == 0, $urandom_range(3) == 0, $urandom_range(7) != 0,
                  $urandom_range(29) == 0, rand_target(), $urandom_range(59) == 0, rand_target(),
                  $urandom_range(1) == 1, $urandom_range(1, 3));
        end
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
